cp0_exc_ctrl: RTL and testbench

Exception/interrupt sequencer that drives the CP0 register block's write side. It samples Status/Cause/EPC from CP0 and exception/ERET requests from the MEM stage, then arbitrates interrupt vs. exception vs. ERET. It performs the CP0 updates as a multi-cycle sequence: EPC write, Cause update, Status EXL set/clear. Finally it redirects the pipeline with flush and a new PC, and stalls the pipeline while busy.

---
 rtl/cp0_exc_ctrl.sv | 144 ++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt/ERET sequencer for the CP0 write side; flush follows acceptance by 4 (exc, EXL=0), 3 (exc, EXL=1) or 2 (ERET) cycles.
// Requests are taken only in IDLE and ignored otherwise; stall_o holds the pipeline while a sequence runs.
module cp0_exc_ctrl #(
  parameter logic [31:0] VEC_BEV    = 32'hBFC0_0380,
  parameter logic [31:0] VEC_NORMAL = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic        exc_bd_i,
  input  logic        eret_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_wdata_o,
  output logic        cause_upd_o,
  output logic [4:0]  cause_exccode_o,
  output logic        cause_bd_o,
  output logic        cause_bd_we_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_o
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WR_EPC      = 3'd1,
    WR_CAUSE    = 3'd2,
    WR_STATUS   = 3'd3,
    ERET_STATUS = 3'd4,
    REDIRECT    = 3'd5
  } state_t;

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  state_t      state;
  state_t      state_nxt;
  logic        int_pend;
  logic        accept;
  logic [4:0]  snap_code;
  logic [31:0] snap_pc;
  logic        snap_bd;
  logic [31:0] snap_status;
  logic [31:0] snap_epc;
  logic        snap_eret;
  logic        unused_cause;

  assign unused_cause = ^{cause_i[31:16], cause_i[7:0]};

  assign int_pend = status_i[0] & ~status_i[1] & (|(status_i[15:8] & cause_i[15:8]));
  assign accept   = (state == IDLE) & (int_pend | exc_valid_i | eret_i);
  assign stall_o  = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Everything the sequence writes comes from this snapshot, so live CP0 changes cannot leak in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_code   <= '0;
      snap_pc     <= '0;
      snap_bd     <= 1'b0;
      snap_status <= '0;
      snap_epc    <= '0;
      snap_eret   <= 1'b0;
    end else if (accept) begin
      snap_code   <= int_pend ? 5'd0 : exc_code_i;
      snap_pc     <= exc_pc_i;
      snap_bd     <= exc_bd_i;
      snap_status <= status_i;
      snap_epc    <= epc_i;
      snap_eret   <= ~int_pend & ~exc_valid_i;
    end
  end

  always_comb begin
    state_nxt       = IDLE;
    cp0_we_o        = 1'b0;
    cp0_waddr_o     = '0;
    cp0_wdata_o     = '0;
    cause_upd_o     = 1'b0;
    cause_exccode_o = '0;
    cause_bd_o      = 1'b0;
    cause_bd_we_o   = 1'b0;
    flush_o         = 1'b0;
    new_pc_o        = '0;
    case (state)
      IDLE: begin
        if (int_pend | exc_valid_i) begin
          state_nxt = status_i[1] ? WR_CAUSE : WR_EPC;
        end else if (eret_i) begin
          state_nxt = ERET_STATUS;
        end
      end
      WR_EPC: begin
        state_nxt   = WR_CAUSE;
        cp0_we_o    = 1'b1;
        cp0_waddr_o = ADDR_EPC;
        cp0_wdata_o = snap_bd ? (snap_pc - 32'd4) : snap_pc;
      end
      WR_CAUSE: begin
        // A nested exception keeps the BD bit of the original one.
        state_nxt       = WR_STATUS;
        cause_upd_o     = 1'b1;
        cause_exccode_o = snap_code;
        cause_bd_we_o   = ~snap_status[1];
        cause_bd_o      = ~snap_status[1] & snap_bd;
      end
      WR_STATUS: begin
        state_nxt   = REDIRECT;
        cp0_we_o    = 1'b1;
        cp0_waddr_o = ADDR_STATUS;
        cp0_wdata_o = snap_status | 32'h2;
      end
      ERET_STATUS: begin
        state_nxt   = REDIRECT;
        cp0_we_o    = 1'b1;
        cp0_waddr_o = ADDR_STATUS;
        cp0_wdata_o = snap_status & ~32'h2;
      end
      REDIRECT: begin
        state_nxt = IDLE;
        flush_o   = 1'b1;
        if (snap_eret) begin
          new_pc_o = snap_epc;
        end else begin
          new_pc_o = snap_status[22] ? VEC_BEV : VEC_NORMAL;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: a request-level model queues expected CP0 events with their cycle;
// a negedge monitor pops and compares whenever the DUT strobes a write, Cause update or flush.
module tb_cp0_exc_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] status_i, cause_i, epc_i, exc_pc_i;
  logic        exc_valid_i, exc_bd_i, eret_i;
  logic [4:0]  exc_code_i;
  logic        cp0_we_o, cause_upd_o, cause_bd_o, cause_bd_we_o, flush_o, stall_o;
  logic [4:0]  cp0_waddr_o, cause_exccode_o;
  logic [31:0] cp0_wdata_o, new_pc_o;

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst),
    .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
    .exc_bd_i(exc_bd_i), .eret_i(eret_i),
    .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o), .cp0_wdata_o(cp0_wdata_o),
    .cause_upd_o(cause_upd_o), .cause_exccode_o(cause_exccode_o),
    .cause_bd_o(cause_bd_o), .cause_bd_we_o(cause_bd_we_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o), .stall_o(stall_o)
  );

  typedef struct {
    int          cyc;
    int          typ;   // 0 = CP0 write, 1 = Cause update, 2 = flush
    logic [4:0]  addr;
    logic [31:0] data;
    logic [4:0]  code;
    logic        bd_we;
    logic        bd;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;
  int  exp_lo = 1;
  int  exp_hi = 0;
  bit  mon_on = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk(input int c, input int t, input logic [4:0] a, input logic [31:0] d,
                             input logic [4:0] code, input logic bdwe, input logic bd);
    ev_t e;
    e.cyc = c; e.typ = t; e.addr = a; e.data = d; e.code = code; e.bd_we = bdwe; e.bd = bd;
    return e;
  endfunction

  // Reference: from one request, list the CP0 side effects in order, one per cycle from cycle a.
  task automatic model(input logic [31:0] st, input logic [31:0] cs, input logic [31:0] epc,
                       input logic ev, input logic [4:0] code, input logic [31:0] pc,
                       input logic bd, input logic er, input int a, output int len);
    logic ip, exl;
    int   k;
    ip  = st[0] && !st[1] && ((st[15:8] & cs[15:8]) != 8'h00);
    exl = st[1];
    k   = a;
    if (ip || ev) begin
      if (!exl) begin
        q.push_back(mk(k, 0, 5'd14, bd ? pc - 32'd4 : pc, 5'd0, 1'b0, 1'b0));
        k++;
      end
      q.push_back(mk(k, 1, 5'd0, 32'd0, ip ? 5'd0 : code, !exl, bd));
      k++;
      q.push_back(mk(k, 0, 5'd12, st | 32'h2, 5'd0, 1'b0, 1'b0));
      k++;
      q.push_back(mk(k, 2, 5'd0, st[22] ? 32'hBFC0_0380 : 32'h8000_0180, 5'd0, 1'b0, 1'b0));
      k++;
    end else if (er) begin
      q.push_back(mk(k, 0, 5'd12, st & ~32'h2, 5'd0, 1'b0, 1'b0));
      k++;
      q.push_back(mk(k, 2, 5'd0, epc, 5'd0, 1'b0, 1'b0));
      k++;
    end
    len = k - a;
  endtask

  task automatic drive(input logic [31:0] st, input logic [31:0] cs, input logic [31:0] epc,
                       input logic ev, input logic [4:0] code, input logic [31:0] pc,
                       input logic bd, input logic er);
    status_i = st; cause_i = cs; epc_i = epc; exc_valid_i = ev;
    exc_code_i = code; exc_pc_i = pc; exc_bd_i = bd; eret_i = er;
  endtask

  task automatic quiet();
    drive(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic junk();
    drive($urandom, $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom, 1'($urandom), 1'($urandom));
  endtask

  // Called just after a rising edge; returns just after the edge that starts the next IDLE cycle.
  task automatic issue(input logic [31:0] st, input logic [31:0] cs, input logic [31:0] epc,
                       input logic ev, input logic [4:0] code, input logic [31:0] pc,
                       input logic bd, input logic er);
    int a, len;
    drive(st, cs, epc, ev, code, pc, bd, er);
    a = cyc + 1;
    model(st, cs, epc, ev, code, pc, bd, er, a, len);
    if (len > 0) begin
      exp_lo = a;
      exp_hi = a + len - 1;
    end
    for (int i = 0; i <= len; i++) begin
      @(posedge clk);
      #1;
      if (i < len) junk();
      else quiet();
    end
  endtask

  always @(negedge clk) begin
    int  nstb, t;
    ev_t e;
    if (mon_on) begin
      chk("stall", 32'(stall_o), (cyc >= exp_lo && cyc <= exp_hi) ? 32'd1 : 32'd0);
      nstb = int'(cp0_we_o) + int'(cause_upd_o) + int'(flush_o);
      if (nstb > 1) begin
        chk("strobe_overlap", 32'(nstb), 32'd1);
      end else if (nstb == 1) begin
        t = cp0_we_o ? 0 : (cause_upd_o ? 1 : 2);
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_event: got type %0d at cycle %0d, expected none", t, cyc);
        end else begin
          e = q.pop_front();
          chk("event_type", 32'(t), 32'(e.typ));
          chk("event_cycle", 32'(cyc), 32'(e.cyc));
          if (e.typ == 0) begin
            chk("wr_addr", 32'(cp0_waddr_o), 32'(e.addr));
            chk("wr_data", cp0_wdata_o, e.data);
          end else if (e.typ == 1) begin
            chk("cause_code", 32'(cause_exccode_o), 32'(e.code));
            chk("cause_bd_we", 32'(cause_bd_we_o), 32'(e.bd_we));
            if (e.bd_we) chk("cause_bd", 32'(cause_bd_o), 32'(e.bd));
          end else begin
            chk("new_pc", new_pc_o, e.data);
          end
        end
      end else begin
        chk("idle_wdata", cp0_wdata_o, 32'd0);
        chk("idle_misc", 32'({cp0_waddr_o, cause_exccode_o, cause_bd_o, cause_bd_we_o}), 32'd0);
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          n_cmp++;
          n_err++;
          $display("FAIL missing_event: type %0d due at cycle %0d, still absent at cycle %0d",
                   q[0].typ, q[0].cyc, cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int a, len;
    rst = 1'b0;
    quiet();
    #3;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_strobes", 32'({cp0_we_o, cause_upd_o, flush_o, cause_bd_we_o, cause_bd_o}), 32'd0);
    chk("rst_addr_code", 32'({cp0_waddr_o, cause_exccode_o}), 32'd0);
    chk("rst_wdata", cp0_wdata_o, 32'd0);
    chk("rst_new_pc", new_pc_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mon_on = 1;
    @(posedge clk);
    #1;

    // Interrupt, delay-slot syscall with BEV, nested exception, ERET
    issue(32'h0000_8001, 32'h0000_8000, 32'h0, 1'b0, 5'd0, 32'h8000_0100, 1'b0, 1'b0);
    issue(32'h0040_0000, 32'h0, 32'h0, 1'b1, 5'd8, 32'h8000_0204, 1'b1, 1'b0);
    issue(32'h0000_0003, 32'h0, 32'h0, 1'b1, 5'd4, 32'h8000_0300, 1'b1, 1'b0);
    issue(32'h0000_0003, 32'h0, 32'h8000_1000, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    // Masked interrupt: nothing accepted
    repeat (4) issue(32'h0000_0001, 32'h0000_FF00, 32'h0, 1'b0, 5'd0, 32'h8000_0400, 1'b0, 1'b0);
    // Interrupt and exception together: interrupt wins
    issue(32'h0000_8001, 32'h0000_8000, 32'h0, 1'b1, 5'd5, 32'h8000_0500, 1'b0, 1'b0);
    // Exception beats ERET
    issue(32'h0000_0000, 32'h0, 32'h1234_5678, 1'b1, 5'd10, 32'h8000_0600, 1'b0, 1'b1);

    // Reset while the Cause update is on the bus
    drive(32'h0, 32'h0, 32'h0, 1'b1, 5'd12, 32'h8000_0040, 1'b0, 1'b0);
    a = cyc + 1;
    model(32'h0, 32'h0, 32'h0, 1'b1, 5'd12, 32'h8000_0040, 1'b0, 1'b0, a, len);
    exp_lo = a;
    exp_hi = a + len - 1;
    @(posedge clk);
    #1;
    quiet();
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall_o), 32'd0);
    chk("midrst_strobes", 32'({cp0_we_o, cause_upd_o, flush_o, cause_bd_we_o, cause_bd_o}), 32'd0);
    chk("midrst_addr_code", 32'({cp0_waddr_o, cause_exccode_o}), 32'd0);
    chk("midrst_wdata", cp0_wdata_o, 32'd0);
    q.delete();
    exp_lo = 1;
    exp_hi = 0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    issue(32'h0000_0401, 32'h0000_0400, 32'h0, 1'b0, 5'd0, 32'h8000_0700, 1'b1, 1'b0);

    // Random requests, often back-to-back, with random CP0 churn while busy
    for (int n = 0; n < 150; n++) begin
      logic [31:0] st;
      st = $urandom;
      if ($urandom_range(0, 1) == 0) st[1:0] = 2'b01;
      issue(st, $urandom, $urandom, ($urandom_range(0, 2) == 0), 5'($urandom), $urandom,
            1'($urandom), ($urandom_range(0, 1) == 0));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (10) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
